spi_cmd_regfile: RTL and testbench
==================================

Name: spi_cmd_regfile

Overview:
- Consumes the byte stream (cmd / cmd_valid) produced by the SPI slave. Drives the slave's response byte.
- Parses framed opcode/data transactions into a small register file.
- Drives four PWM-dimmed LED outputs from that register file.
- Replaces the top-level single-byte last_cmd latch with a real addressed protocol.

Parameters:
- NUM_LEDS, 4, number of PWM LED outputs; must be ≤ 4 at this register map.
- PWM_WIDTH, 8, width of PWM counter and duty registers.
- ID_BYTE, 8'hA8, constant value returned by the read-only ID register and as the idle response.

Ports:
- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- spi_ssel  in  1  raw SPI chip select, active-low, asynchronous to clk
- cmd  in  8  received byte from SPI slave
- cmd_valid  in  1  one-clk pulse, cmd valid
- response  out  8  byte the SPI slave shifts out on the next byte slot
- led  out  NUM_LEDS  PWM LED drive, active-high
- err_pulse  out  1  one-clk pulse on protocol error

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE; response=ID_BYTE; led=0; err_pulse=0.
- Reset values of registers: regs 0–4 and 6–7 reset to 0; reg5 is the constant ID. PWM counter=0.
- spi_ssel sync: two-flop synchroniser into clk domain.
- Frame end: a synchronised rising edge of ssel (deselect) forces FSM→IDLE in the next cycle, regardless of state. This takes priority over a simultaneous cmd_valid.
- Register map (addr[2:0]):
  - 0: LED enable mask, bits[3:0].
  - 1–4: duty for led[0..3].
  - 5: ID, read-only.
  - 6: scratch, R/W.
  - 7: error count, saturating at 255; any write clears it.
- Opcode byte: bit7=1 write, 0 read; bits[6:3] must be 0; bits[2:0] are the address.
- FSM states:
  - IDLE: first cmd_valid in a frame → decode. Reserved bits nonzero → ERROR. Write → WDATA. Read → RDATA.
  - WDATA: next cmd_valid writes cmd to reg[addr] (writes to reg5 are ignored), then → DONE.
  - RDATA: the response already presented; the next cmd_valid (dummy byte) → DONE.
  - DONE: further bytes are extra. Without burst, each extra byte raises an error; the FSM stays in DONE.
  - ERROR: swallows all bytes until frame end; no register side effects.
- Error: one-cycle err_pulse plus error-count increment, once per offending byte.
- Response timing:
  - response is registered and updated exactly 1 clk after the cmd_valid that decodes a read.
  - Value is reg[addr]; it holds until the next cmd_valid.
  - In all other states response=ID_BYTE.
- PWM:
  - Free-running PWM_WIDTH counter, wrapping 2^PWM_WIDTH−1 → 0.
  - led[i] = mask[i] && (counter < duty[i]), registered.
  - duty=0 → always off. duty=255 → on 255/256.
  - Duty writes take effect at the next counter wrap (shadowed), to avoid glitching.
- A cmd_valid arriving while ssel is deselected is ignored.

Optional Feature:
- Macro: SPI_CMD_BURST_EN.
- Defined:
  - In WDATA, a write byte keeps the FSM in WDATA and increments the address, wrapping 7→0. Writes to reg5 are skipped silently.
  - In RDATA, each dummy byte increments the address and reloads the response with the next register.
  - Bursts are bounded only by frame end.
- Undefined: single-access behaviour as above; extra bytes in DONE raise errors.

Decomposition:
- Package spi_cmd_pkg:
  - FSM state enum (IDLE, WDATA, RDATA, DONE, ERROR).
  - Register address localparams (ADDR_MASK, ADDR_DUTY0..3, ADDR_ID, ADDR_SCRATCH, ADDR_ERRCNT).
  - Opcode bit positions.
- One sub-module: pwm_channel. Holds the shadowed duty register and the compare, and is instantiated NUM_LEDS times against the shared counter.

Test Plan:
- Reset → response=8'hA8, led=0, all regs read 0 except ID=8'hA8.
- Frame [8'h81, 8'h80], frame [8'h80, 8'h0F] → after one PWM period, led[0] high for 128 of 256 clks; other LEDs low.
- Frame [8'h05, 8'h00] → response=8'hA8 one clk after first cmd_valid. Frame [8'h86,8'h5A], then [8'h06,8'h00] → response=8'h5A.
- Frame [8'h48] → err_pulse for 1 clk, error count=1, no register written. Frame [8'h87,8'h00] → count=0.
- Deselect mid-WDATA after the opcode only → no write occurs. The next frame decodes a fresh opcode correctly.
- Burst (SPI_CMD_BURST_EN): [8'h81, 8'h10, 8'h20, 8'h30, 8'h40] → duty1..4 = 10,20,30,40. Without the macro: duty1=8'h10, 3 err pulses, error count=3.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, register address map, opcode bit positions.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Register map, indexed by opcode bits [2:0]
    localparam logic [2:0] ADDR_MASK    = 3'd0;
    localparam logic [2:0] ADDR_DUTY0   = 3'd1;
    localparam logic [2:0] ADDR_DUTY1   = 3'd2;
    localparam logic [2:0] ADDR_DUTY2   = 3'd3;
    localparam logic [2:0] ADDR_DUTY3   = 3'd4;
    localparam logic [2:0] ADDR_ID      = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH = 3'd6;
    localparam logic [2:0] ADDR_ERRCNT  = 3'd7;

    // Opcode byte layout: [7] write, [6:3] reserved (must be 0), [2:0] address
    localparam int OP_WRITE_BIT = 7;
    localparam int OP_RSVD_MSB  = 6;
    localparam int OP_RSVD_LSB  = 3;
    localparam int OP_ADDR_MSB  = 2;
    localparam int OP_ADDR_LSB  = 0;

    function automatic logic op_rsvd_bad(input logic [7:0] op);
        return |op[OP_RSVD_MSB:OP_RSVD_LSB];
    endfunction

    function automatic logic [2:0] op_addr(input logic [7:0] op);
        return op[OP_ADDR_MSB:OP_ADDR_LSB];
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: shadowed duty register compared against a shared free-running counter.
// Latency: led is registered, one clk behind the counter value it was compared with.
// Backpressure: none; duty is sampled into the shadow only on the counter wrap cycle.
//
// Ports: clk, rst_n; cnt/cnt_wrap from the shared counter; duty (live register value);
//        enable (mask bit); led (registered drive).
module pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic                 cnt_wrap,
    input  logic [PWM_WIDTH-1:0] duty,
    input  logic                 enable,
    output logic                 led
);

    logic [PWM_WIDTH-1:0] duty_shadow;

    // Shadow reloads as the counter rolls over so a period never mixes two duties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= '0;
            led         <= 1'b0;
        end else begin
            if (cnt_wrap) begin
                duty_shadow <= duty;
            end
            led <= enable && (cnt < duty_shadow);
        end
    end

endmodule

// File: rtl/spi_cmd_regfile.sv
// Framed opcode/data SPI command parser feeding a small register file that drives PWM LEDs.
// Latency: register writes and read responses land 1 clk after the accepted cmd_valid.
// Backpressure: none; every cmd_valid seen while selected is consumed, deselected bytes are dropped.
//
// Ports: clk, rst_n (async active-low); spi_ssel (raw, async, active-low chip select);
//        cmd/cmd_valid (byte stream from the SPI slave); response (byte for the next slot);
//        led[NUM_LEDS] (PWM drive); err_pulse (one clk per offending byte).
// Build option: define SPI_CMD_BURST_EN for auto-incrementing burst reads/writes.
module spi_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter int          NUM_LEDS  = 4,     // at most 4 with this register map
    parameter int          PWM_WIDTH = 8,
    parameter logic [7:0]  ID_BYTE   = 8'hA8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_ssel,
    input  logic [7:0]          cmd,
    input  logic                cmd_valid,
    output logic [7:0]          response,
    output logic [NUM_LEDS-1:0] led,
    output logic                err_pulse
);

    // ---------------- chip-select synchroniser ----------------
    logic ssel_meta, ssel_sync, ssel_prev;
    logic ssel_rise, byte_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel_meta <= 1'b1;
            ssel_sync <= 1'b1;
            ssel_prev <= 1'b1;
        end else begin
            ssel_meta <= spi_ssel;
            ssel_sync <= ssel_meta;
            ssel_prev <= ssel_sync;
        end
    end

    assign ssel_rise = ssel_sync & ~ssel_prev;
    assign byte_vld  = cmd_valid & ~ssel_sync;

    // ---------------- register file ----------------
    logic [3:0]       mask_q;
    logic [3:0][7:0]  duty_q;
    logic [7:0]       scratch_q;
    logic [7:0]       errcnt_q;
    logic [7:0]       reg_rd [8];

    always_comb begin
        reg_rd[ADDR_MASK]    = {4'h0, mask_q};
        reg_rd[ADDR_DUTY0]   = duty_q[0];
        reg_rd[ADDR_DUTY1]   = duty_q[1];
        reg_rd[ADDR_DUTY2]   = duty_q[2];
        reg_rd[ADDR_DUTY3]   = duty_q[3];
        reg_rd[ADDR_ID]      = ID_BYTE;
        reg_rd[ADDR_SCRATCH] = scratch_q;
        reg_rd[ADDR_ERRCNT]  = errcnt_q;
    end

    // ---------------- frame FSM ----------------
    state_t     state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] resp_d;
    logic       wr_en;
    logic       err_evt;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        resp_d  = response;
        wr_en   = 1'b0;
        err_evt = 1'b0;

        if (ssel_rise) begin
            state_d = ST_IDLE;
        end else if (byte_vld) begin
            case (state_q)
                ST_IDLE: begin
                    addr_d = op_addr(cmd);
                    if (op_rsvd_bad(cmd)) begin
                        state_d = ST_ERROR;
                        err_evt = 1'b1;
                    end else if (cmd[OP_WRITE_BIT]) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RDATA;
                        resp_d  = reg_rd[op_addr(cmd)];
                    end
                end
                ST_WDATA: begin
                    // Writes to the ID address fall through the write case untouched.
                    wr_en = 1'b1;
`ifdef SPI_CMD_BURST_EN
                    addr_d = addr_q + 3'd1;
`else
                    state_d = ST_DONE;
`endif
                end
                ST_RDATA: begin
`ifdef SPI_CMD_BURST_EN
                    addr_d = addr_q + 3'd1;
                    resp_d = reg_rd[addr_q + 3'd1];
`else
                    state_d = ST_DONE;
`endif
                end
                ST_DONE: begin
                    err_evt = 1'b1;
                end
                ST_ERROR: begin
                    // Bytes are swallowed until the frame ends.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // The response only carries register data while a read is open.
        if (state_d != ST_RDATA) begin
            resp_d = ID_BYTE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            response  <= ID_BYTE;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            response  <= resp_d;
            err_pulse <= err_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            duty_q    <= '0;
            scratch_q <= '0;
            errcnt_q  <= '0;
        end else if (wr_en) begin
            case (addr_q)
                ADDR_MASK:    mask_q    <= cmd[3:0];
                ADDR_DUTY0:   duty_q[0] <= cmd;
                ADDR_DUTY1:   duty_q[1] <= cmd;
                ADDR_DUTY2:   duty_q[2] <= cmd;
                ADDR_DUTY3:   duty_q[3] <= cmd;
                ADDR_SCRATCH: scratch_q <= cmd;
                ADDR_ERRCNT:  errcnt_q  <= '0;   // any write clears the count
                default:      ;                  // ID is read-only
            endcase
        end else if (err_evt && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    // ---------------- PWM ----------------
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 pwm_wrap;

    assign pwm_wrap = &pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_pwm
        pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_pwm (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (pwm_cnt),
            .cnt_wrap (pwm_wrap),
            .duty     (PWM_WIDTH'(duty_q[i])),
            .enable   (mask_q[i]),
            .led      (led[i])
        );
    end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Self-checking bench for spi_cmd_regfile: directed frames plus random frames vs a frame-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_spi_cmd_regfile;

    localparam logic [7:0] ID = 8'hA8;
`ifdef SPI_CMD_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_ssel = 1'b1;
    logic [7:0] cmd = 8'h00;
    logic       cmd_valid = 1'b0;
    logic [7:0] response;
    logic [3:0] led;
    logic       err_pulse;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    spi_cmd_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_ssel  (spi_ssel),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .response  (response),
        .led       (led),
        .err_pulse (err_pulse)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_reg [8];
    logic [7:0] fq [$];
    logic [7:0] exp_resp [$];
    bit         exp_err [$];

    function automatic void m_write(input logic [2:0] a, input logic [7:0] v);
        case (a)
            3'd0:    m_reg[0] = v & 8'h0F;
            3'd5:    ;
            3'd7:    m_reg[7] = 8'h00;
            default: m_reg[a] = v;
        endcase
    endfunction

    // Walks a whole frame and records, per byte, the expected response and error flag.
    function automatic void model_frame();
        logic [7:0] op;
        logic [2:0] a;
        logic [7:0] r;
        bit         e;
        exp_resp.delete();
        exp_err.delete();
        op = fq[0];
        a  = op[2:0];
        for (int i = 0; i < fq.size(); i++) begin
            r = ID;
            e = 1'b0;
            if (op[6:3] != 4'd0) begin
                e = (i == 0);
            end else if (op[7]) begin
                if (i > 0) begin
                    if (BURST) begin
                        m_write(a, fq[i]);
                        a = a + 3'd1;
                    end else if (i == 1) begin
                        m_write(a, fq[i]);
                    end else begin
                        e = 1'b1;
                    end
                end
            end else begin
                if (i == 0) begin
                    r = m_reg[a];
                end else if (BURST) begin
                    a = a + 3'd1;
                    r = m_reg[a];
                end else if (i > 1) begin
                    e = 1'b1;
                end
            end
            if (e && m_reg[7] != 8'hFF) m_reg[7] = m_reg[7] + 8'd1;
            exp_resp.push_back(r);
            exp_err.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives the frame in fq, one byte every other cycle, then deselects.
    task automatic send_frame();
        model_frame();
        spi_ssel = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < fq.size(); i++) begin
            cmd       = fq[i];
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            if (err_pulse === 1'b1) err_seen++;
            chk("resp", response, exp_resp[i]);
            chk("err", err_pulse, exp_err[i]);
            @(negedge clk);
            chk("resp_hold", response, exp_resp[i]);
            chk("err_1clk", err_pulse, 1'b0);
        end
        spi_ssel = 1'b1;
        repeat (4) @(negedge clk);
        chk("resp_frame_end", response, ID);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) begin
            fq = {8'(a), 8'h00};
            send_frame();
        end
    endtask

    // Counts LED high cycles over one full PWM period after the shadows have settled.
    task automatic pwm_check();
        int cnt [4];
        repeat (600) @(negedge clk);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 4; i++) if (led[i] === 1'b1) cnt[i]++;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++)
            chk("pwm_on_count", cnt[i], m_reg[0][i] ? 32'(m_reg[i+1]) : 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 8; a++) m_reg[a] = 8'h00;
        m_reg[5] = ID;

        repeat (3) @(negedge clk);
        chk("rst_resp", response, ID);
        chk("rst_led", led, 4'h0);
        chk("rst_err", err_pulse, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        read_all();

        // duty0 = 0x80, all LEDs enabled -> led[0] on for half a period
        fq = {8'h81, 8'h80}; send_frame();
        fq = {8'h80, 8'h0F}; send_frame();
        pwm_check();
        // full-scale duty on led[1]
        fq = {8'h82, 8'hFF}; send_frame();
        pwm_check();

        fq = {8'h05, 8'h00}; send_frame();
        fq = {8'h86, 8'h5A}; send_frame();
        fq = {8'h06, 8'h00}; send_frame();

        // reserved bits set -> error, then clear the count
        err_seen = 0;
        fq = {8'h48}; send_frame();
        chk("rsvd_err_pulses", err_seen, 1);
        fq = {8'h07, 8'h00}; send_frame();
        fq = {8'h87, 8'h00}; send_frame();
        fq = {8'h07, 8'h00}; send_frame();

        // deselect after write opcode only, then a fresh read
        fq = {8'h86}; send_frame();
        fq = {8'h06, 8'h00}; send_frame();

        // multi-byte write frame
        err_seen = 0;
        fq = {8'h81, 8'h10, 8'h20, 8'h30, 8'h40}; send_frame();
        chk("extra_byte_errs", err_seen, BURST ? 0 : 3);
        read_all();

        // byte while deselected must be ignored
        @(negedge clk);
        cmd = 8'h48; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("deselected_err", err_pulse, 1'b0);
        fq = {8'h07, 8'h00}; send_frame();

        // error count saturation
        for (int n = 0; n < 260; n++) begin
            fq = {8'h48}; send_frame();
        end
        fq = {8'h07, 8'h00}; send_frame();
        fq = {8'h87, 8'h00}; send_frame();

        // random frames
        for (int n = 0; n < 60; n++) begin
            logic [7:0] op;
            int len;
            len = $urandom_range(1, 4);
            if ($urandom_range(0, 3) == 0) op = 8'($urandom);
            else op = {1'($urandom_range(0, 1)), 4'h0, 3'($urandom_range(0, 7))};
            fq = {op};
            for (int i = 1; i < len; i++) fq.push_back(8'($urandom));
            send_frame();
        end
        read_all();
        pwm_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
